// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one external read channel between conv1/conv2/ip1 DMA requesters.
// Request to mem_rd_req_o: 1 cycle; return data to layer: 0 cycles; backpressure by holding ISSUE until mem_rd_ack_i.
module dma_read_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len_i,
    output logic [N_REQ-1:0]            req_ack_o,
    output logic [DATA_WIDTH-1:0]       req_dout_o,
    output logic [N_REQ-1:0]            req_dout_en_o,
    output logic [N_REQ-1:0]            req_dout_eop_o,
    output logic                        mem_rd_req_o,
    output logic [ADDR_WIDTH-1:0]       mem_rd_addr_o,
    output logic [LEN_WIDTH-1:0]        mem_rd_len_o,
    input  logic                        mem_rd_ack_i,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data_i,
    input  logic                        mem_rd_en_i,
    input  logic                        mem_rd_eop_i,
    output logic                        busy_o,
    output logic [1:0]                  grant_o,
    output logic                        err_o,
    input  logic                        err_clr_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_ZLEN} state_t;

    localparam logic [LEN_WIDTH:0] CNT_MAX   = '1;
    localparam logic [1:0]         GRANT_RST = 2'(N_REQ - 1);

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH:0]      cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic                    win_vld;
    logic [1:0]              win_idx;
    int                      cand;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LEN_WIDTH-1:0]    sel_len;
    logic [N_REQ-1:0]        gmask;
    logic [LEN_WIDTH:0]      cnt_inc;
    logic                    err_set;
    logic                    xfer, zlen;

    // Walk from furthest to nearest so the requester closest after last grant wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = grant_q;
        cand    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(grant_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (req_i[cand[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        gmask    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(win_idx) == i) begin
                sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
            gmask[i] = (int'(grant_q) == i);
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d = win_idx;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    state_d = (sel_len == '0) ? S_ZLEN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_rd_ack_i) begin
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (mem_rd_en_i) begin
                    cnt_d = cnt_inc;
                    if (mem_rd_eop_i) begin
                        err_set = (cnt_inc != {1'b0, len_q});
                        state_d = S_IDLE;
                    end else if (cnt_inc >= {1'b0, len_q}) begin
                        // Length exhausted but no eop yet: flag and keep forwarding.
                        err_set = 1'b1;
                    end
                end
            end
            S_ZLEN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        err_d = (err_q & ~err_clr_i) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= GRANT_RST;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign xfer           = (state_q == S_XFER);
    assign zlen           = (state_q == S_ZLEN);
    assign busy_o         = (state_q != S_IDLE);
    assign mem_rd_req_o   = (state_q == S_ISSUE);
    assign mem_rd_addr_o  = addr_q;
    assign mem_rd_len_o   = len_q;
    assign grant_o        = grant_q;
    assign err_o          = err_q;
    assign req_ack_o      = (ack_q || zlen) ? gmask : '0;
    assign req_dout_en_o  = (xfer && mem_rd_en_i) ? gmask : '0;
    assign req_dout_eop_o = ((xfer && mem_rd_en_i && mem_rd_eop_i) || zlen) ? gmask : '0;
    assign req_dout_o     = xfer ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Directed vector bench for dma_read_arbiter: per-cycle stimulus with hand-computed expected outputs.
module tb_dma_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_ack, req_dout_en, req_dout_eop;
    logic [DW-1:0]   req_dout;
    logic            mem_rd_req;
    logic [AW-1:0]   mem_rd_addr;
    logic [LW-1:0]   mem_rd_len;
    logic            mem_rd_ack = 1'b0;
    logic [DW-1:0]   mem_rd_data = '0;
    logic            mem_rd_en = 1'b0;
    logic            mem_rd_eop = 1'b0;
    logic            busy;
    logic [1:0]      grant;
    logic            err;
    logic            err_clr = 1'b0;

    logic [AW-1:0]   addr_cfg [N];
    logic [LW-1:0]   len_cfg  [N];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign req_addr = {addr_cfg[2], addr_cfg[1], addr_cfg[0]};
    assign req_len  = {len_cfg[2], len_cfg[1], len_cfg[0]};

    dma_read_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_ack_o(req_ack), .req_dout_o(req_dout),
        .req_dout_en_o(req_dout_en), .req_dout_eop_o(req_dout_eop),
        .mem_rd_req_o(mem_rd_req), .mem_rd_addr_o(mem_rd_addr), .mem_rd_len_o(mem_rd_len),
        .mem_rd_ack_i(mem_rd_ack), .mem_rd_data_i(mem_rd_data),
        .mem_rd_en_i(mem_rd_en), .mem_rd_eop_i(mem_rd_eop),
        .busy_o(busy), .grant_o(grant), .err_o(err), .err_clr_i(err_clr)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        mack, men, meop;
        logic [15:0] mdat;
        logic        clr;
        logic [2:0]  xack, xen, xeop;
        logic        xmreq, xbusy;
        logic [1:0]  xgrant;
        logic        xerr;
        logic [15:0] xdout;
    } vec_t;

    function automatic vec_t mk(input int r, rq, ma, me, mo, md, c,
                                input int xa, xe, xo, xm, xb, xg, xr, xd);
        vec_t v;
        v.rst = 1'(r);   v.req = 3'(rq);  v.mack = 1'(ma); v.men = 1'(me);
        v.meop = 1'(mo); v.mdat = 16'(md); v.clr = 1'(c);
        v.xack = 3'(xa); v.xen = 3'(xe);  v.xeop = 3'(xo); v.xmreq = 1'(xm);
        v.xbusy = 1'(xb); v.xgrant = 2'(xg); v.xerr = 1'(xr); v.xdout = 16'(xd);
        return v;
    endfunction

    // Apply one cycle of inputs, compare settled outputs mid-cycle, then advance past the next edge.
    task automatic run_vec(input vec_t v, input string tag);
        logic [30:0] got, exp;
        rst = v.rst; req = v.req; mem_rd_ack = v.mack; mem_rd_en = v.men;
        mem_rd_eop = v.meop; mem_rd_data = v.mdat; err_clr = v.clr;
        #1;
        got = {req_ack, req_dout_en, req_dout_eop, mem_rd_req, busy, grant, err, req_dout};
        exp = {v.xack, v.xen, v.xeop, v.xmreq, v.xbusy, v.xgrant, v.xerr, v.xdout};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s outputs: got ack=%b en=%b eop=%b mreq=%b busy=%b grant=%0d err=%b dout=%h, want ack=%b en=%b eop=%b mreq=%b busy=%b grant=%0d err=%b dout=%h",
                     tag, req_ack, req_dout_en, req_dout_eop, mem_rd_req, busy, grant, err, req_dout,
                     v.xack, v.xen, v.xeop, v.xmreq, v.xbusy, v.xgrant, v.xerr, v.xdout);
        end
        if (v.xmreq) begin
            n_chk++;
            if (mem_rd_addr !== addr_cfg[v.xgrant] || mem_rd_len !== len_cfg[v.xgrant]) begin
                n_fail++;
                $display("FAIL %s mem_rd addr/len: got %h/%0d, want %h/%0d", tag,
                         mem_rd_addr, mem_rd_len, addr_cfg[v.xgrant], len_cfg[v.xgrant]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        addr_cfg[0] = 32'h100; addr_cfg[1] = 32'h200; addr_cfg[2] = 32'h300;
        len_cfg[0]  = 16'd4;   len_cfg[1]  = 16'd0;   len_cfg[2]  = 16'd2;

        //            rst rq ma me mo mdat     clr  ack en eop mrq bsy gnt err dout
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 2, 0, 0));
        // conv1 single burst, len 4
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 'hA001,  0,  1, 1, 0, 0, 1, 0, 0, 'hA001));
        tbl.push_back(mk(0, 0, 0, 1, 0, 'hA002,  0,  0, 1, 0, 0, 1, 0, 0, 'hA002));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 'hA003,  0,  0, 1, 0, 0, 1, 0, 0, 'hA003));
        tbl.push_back(mk(0, 0, 0, 1, 1, 'hA004,  0,  0, 1, 1, 0, 1, 0, 0, 'hA004));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0, 0));
        // stray memory data while idle
        tbl.push_back(mk(0, 0, 0, 1, 1, 'hBEEF,  0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0, 0));
        // reset, then all three request together: 0 (len4), 1 (zero len), 2 (len2), 0 again
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7, 1, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 7, 0, 1, 0, 'h0101,  0,  1, 1, 0, 0, 1, 0, 0, 'h0101));
        tbl.push_back(mk(0, 7, 0, 1, 0, 'h0102,  0,  0, 1, 0, 0, 1, 0, 0, 'h0102));
        tbl.push_back(mk(0, 7, 0, 1, 0, 'h0103,  0,  0, 1, 0, 0, 1, 0, 0, 'h0103));
        tbl.push_back(mk(0, 7, 0, 1, 1, 'h0104,  0,  0, 1, 1, 0, 1, 0, 0, 'h0104));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  2, 0, 2, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 7, 1, 0, 0, 0,       0,  0, 0, 0, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 7, 0, 1, 0, 'h0301,  0,  4, 4, 0, 0, 1, 2, 0, 'h0301));
        tbl.push_back(mk(0, 7, 0, 1, 1, 'h0302,  0,  0, 4, 4, 0, 1, 2, 0, 'h0302));
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 2, 0, 0));
        // second grant to 0; its req drops after grant, early eop flags error, then clear
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,       0,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 'h0111,  0,  1, 1, 1, 0, 1, 0, 0, 'h0111));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       1,  0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,       0,  0, 0, 0, 0, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // Short burst: len 5, eop on 3rd beat; error sticks, then clear coinciding with a new error
        len_cfg[0] = 16'd5;
        run_vec(mk(0, 1, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0), "short idle");
        run_vec(mk(0, 1, 1, 0, 0, 0,      0,  0, 0, 0, 1, 1, 0, 0, 0), "short issue");
        run_vec(mk(0, 0, 0, 1, 0, 'h5001, 0,  1, 1, 0, 0, 1, 0, 0, 'h5001), "short b1");
        run_vec(mk(0, 0, 0, 1, 0, 'h5002, 0,  0, 1, 0, 0, 1, 0, 0, 'h5002), "short b2");
        run_vec(mk(0, 0, 0, 1, 1, 'h5003, 0,  0, 1, 1, 0, 1, 0, 0, 'h5003), "short eop");
        run_vec(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 1, 0), "short err rise");
        run_vec(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 1, 0), "short err hold");
        run_vec(mk(0, 1, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 1, 0), "short2 idle");
        run_vec(mk(0, 1, 1, 0, 0, 0,      0,  0, 0, 0, 1, 1, 0, 1, 0), "short2 issue");
        run_vec(mk(0, 0, 0, 1, 1, 'h5011, 1,  1, 1, 1, 0, 1, 0, 1, 'h5011), "short2 eop+clr");
        run_vec(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 1, 0), "set beats clr");
        run_vec(mk(0, 0, 0, 0, 0, 0,      1,  0, 0, 0, 0, 0, 0, 1, 0), "clr pulse");
        run_vec(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0), "err cleared");

        // Reset during an 8-beat burst after 2 beats
        len_cfg[0] = 16'd8;
        run_vec(mk(0, 1, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0), "rstx idle");
        run_vec(mk(0, 1, 1, 0, 0, 0,      0,  0, 0, 0, 1, 1, 0, 0, 0), "rstx issue");
        run_vec(mk(0, 0, 0, 1, 0, 'h8001, 0,  1, 1, 0, 0, 1, 0, 0, 'h8001), "rstx b1");
        run_vec(mk(0, 0, 0, 1, 0, 'h8002, 0,  0, 1, 0, 0, 1, 0, 0, 'h8002), "rstx b2");
        run_vec(mk(1, 0, 0, 1, 0, 'h8003, 0,  0, 0, 0, 0, 0, 2, 0, 0), "rstx in reset");
        run_vec(mk(0, 0, 0, 1, 0, 'h8004, 0,  0, 0, 0, 0, 0, 2, 0, 0), "rstx drop b4");
        run_vec(mk(0, 0, 0, 1, 1, 'h8005, 0,  0, 0, 0, 0, 0, 2, 0, 0), "rstx drop eop");
        run_vec(mk(0, 7, 0, 0, 0, 0,      0,  0, 0, 0, 0, 0, 2, 0, 0), "rstx rereq");
        run_vec(mk(0, 0, 0, 0, 0, 0,      0,  0, 0, 0, 1, 1, 0, 0, 0), "rstx grant0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
